// File: rtl/dm_cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller with 32-byte lines.
// Serves 32-bit CPU loads/stores and initiates block writebacks and fills to main memory.
module dm_cache_controller #(
    parameter int NUM_LINES = 8,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_write_en_block,
    output logic [ADDR_W-1:0] mem_block_addr_wr,
    output logic [255:0]      mem_write_block,
    output logic              mem_read_block_en,
    output logic [ADDR_W-1:0] mem_block_addr_rd,
    input  logic [255:0]      mem_read_block_in,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);
    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = ADDR_W - 5 - INDEX_W;

    // state     | meaning
    // IDLE      | waiting for cpu_req; latches the request on acceptance
    // COMPARE   | tag lookup; completes on hit, else picks writeback or allocate
    // WRITEBACK | dirty victim line driven to memory for one cycle
    // ALLOCATE  | block read strobe for the requested line
    // FILL      | memory data captured into the line, then re-compare
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        ALLOCATE  = 3'd3,
        FILL      = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [2:0]         req_word;
    logic               req_we;
    logic [31:0]        req_wdata;
    logic               first_lookup;

    logic [NUM_LINES-1:0] line_valid;
    logic [NUM_LINES-1:0] line_dirty;
    logic [TAG_W-1:0]     line_tag  [NUM_LINES];
    logic [255:0]         line_data [NUM_LINES];

    logic         accept;
    logic         hit;
    logic         victim_dirty;
    logic [255:0] cur_line;
    logic         addr_lsb_unused;

    assign addr_lsb_unused = ^cpu_addr[1:0];

    // The CPU drops cpu_req on the edge after it sees cpu_ready, so ignore that cycle.
    assign accept       = (state == IDLE) && cpu_req && !cpu_ready;
    assign cur_line     = line_data[req_index];
    assign hit          = line_valid[req_index] && (line_tag[req_index] == req_tag);
    assign victim_dirty = line_valid[req_index] && line_dirty[req_index];

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Enables are decoded from state and gated by reset so they never assert in a reset cycle.
    always_comb begin
        state_next         = state;
        mem_write_en_block = 1'b0;
        mem_read_block_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_next = COMPARE;
            end
            COMPARE: begin
                if (hit)               state_next = IDLE;
                else if (victim_dirty) state_next = WRITEBACK;
                else                   state_next = ALLOCATE;
            end
            WRITEBACK: begin
                mem_write_en_block = !reset;
                state_next         = ALLOCATE;
            end
            ALLOCATE: begin
                mem_read_block_en = !reset;
                state_next        = FILL;
            end
            FILL: begin
                state_next = COMPARE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_tag           <= '0;
            req_index         <= '0;
            req_word          <= '0;
            req_we            <= 1'b0;
            req_wdata         <= '0;
            first_lookup      <= 1'b0;
            line_valid        <= '0;
            line_dirty        <= '0;
            cpu_ready         <= 1'b0;
            cpu_rdata         <= '0;
            hit_count         <= '0;
            miss_count        <= '0;
            mem_block_addr_wr <= '0;
            mem_write_block   <= '0;
            mem_block_addr_rd <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_tag      <= cpu_addr[ADDR_W-1 -: TAG_W];
                        req_index    <= cpu_addr[5 +: INDEX_W];
                        req_word     <= cpu_addr[4:2];
                        req_we       <= cpu_we;
                        req_wdata    <= cpu_wdata;
                        first_lookup <= 1'b1;
                    end
                end
                COMPARE: begin
                    first_lookup <= 1'b0;
                    if (first_lookup) begin
                        if (hit) hit_count  <= sat_inc(hit_count);
                        else     miss_count <= sat_inc(miss_count);
                    end
                    if (hit) begin
                        cpu_ready <= 1'b1;
                        if (req_we) line_dirty[req_index] <= 1'b1;
                        else        cpu_rdata <= cur_line[{req_word, 5'b0} +: 32];
                    end else begin
                        mem_block_addr_wr <= {line_tag[req_index], req_index, 5'b0};
                        mem_write_block   <= cur_line;
                        mem_block_addr_rd <= {req_tag, req_index, 5'b0};
                    end
                end
                FILL: begin
                    line_valid[req_index] <= 1'b1;
                    line_dirty[req_index] <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Tag and data storage need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == FILL) begin
                line_tag[req_index]  <= req_tag;
                line_data[req_index] <= mem_read_block_in;
            end else if ((state == COMPARE) && hit && req_we) begin
                line_data[req_index][{req_word, 5'b0} +: 32] <= req_wdata;
            end
        end
    end

endmodule
